// File: rtl/nanov_spi_ram_responder.sv
// SPI RAM responder: decodes READ (0x03) / WRITE (0x02) + 24-bit address one bit per clk
// and serves a small byte-addressed RAM, with a parallel host port for preload/inspection.
module nanov_spi_ram_responder #(
  parameter int unsigned ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spi_cs_n,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 busy,
  input  logic                 host_wr_en,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic [7:0]           host_wdata,
  output logic [7:0]           host_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam int unsigned CNT_W = 5;

  localparam logic [7:0]       CMD_READ    = 8'h03;
  localparam logic [7:0]       CMD_WRITE   = 8'h02;
  localparam logic [CNT_W-1:0] CNT_BYTE_END = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_ADDR_END = CNT_W'(23);
  localparam logic [CNT_W-1:0] CNT_RD_DONE  = CNT_W'(8);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    READ,
    WRITE,
    IGNORE
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [6:0]           cmd_sr;
  logic                 is_read;
  logic [ADDR_BITS-1:0] addr;
  logic [6:0]           rd_sr;
  logic [6:0]           wr_sr;
  logic [7:0]           mem [DEPTH];

  logic [7:0]           cmd_c;
  logic [ADDR_BITS-1:0] addr_shift_c;
  logic [ADDR_BITS-1:0] addr_inc_c;
  logic                 spi_we_c;
  logic [7:0]           spi_wdata_c;

  // Only the low ADDR_BITS of the 24-bit address survive the shift.
  assign cmd_c        = {cmd_sr, spi_mosi};
  assign addr_shift_c = {addr[ADDR_BITS-2:0], spi_mosi};
  assign addr_inc_c   = addr + ADDR_BITS'(1);
  assign spi_we_c     = !rst && !spi_cs_n && (state == WRITE) && (cnt == CNT_BYTE_END);
  assign spi_wdata_c  = {wr_sr, spi_mosi};
  assign host_rdata   = mem[host_addr];

  // RAM is never reset; the SPI commit is written last so it wins a same-byte collision.
  always_ff @(posedge clk) begin
    if (host_wr_en) mem[host_addr] <= host_wdata;
    if (spi_we_c)   mem[addr]      <= spi_wdata_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      spi_miso <= 1'b0;
      busy     <= 1'b0;
      cnt      <= '0;
      addr     <= '0;
      cmd_sr   <= '0;
      is_read  <= 1'b0;
      rd_sr    <= '0;
      wr_sr    <= '0;
    end else if (spi_cs_n) begin
      state    <= IDLE;
      spi_miso <= 1'b0;
      busy     <= 1'b0;
      cnt      <= '0;
      wr_sr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_sr <= {6'b0, spi_mosi};
          cnt    <= CNT_W'(1);
          state  <= CMD;
        end
        CMD: begin
          cmd_sr <= {cmd_sr[5:0], spi_mosi};
          if (cnt == CNT_BYTE_END) begin
            cnt     <= '0;
            is_read <= (cmd_c == CMD_READ);
            if (cmd_c == CMD_READ || cmd_c == CMD_WRITE) state <= ADDR;
            else                                         state <= IGNORE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ADDR: begin
          addr <= addr_shift_c;
          if (cnt == CNT_ADDR_END) begin
            busy <= 1'b1;
            if (is_read) begin
              // First data bit is presented on the edge that samples the last address bit.
              rd_sr    <= mem[addr_shift_c][6:0];
              spi_miso <= mem[addr_shift_c][7];
              cnt      <= CNT_W'(1);
              state    <= READ;
            end else begin
              cnt   <= '0;
              state <= WRITE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        READ: begin
          if (cnt == CNT_RD_DONE) begin
            addr     <= addr_inc_c;
            rd_sr    <= mem[addr_inc_c][6:0];
            spi_miso <= mem[addr_inc_c][7];
            cnt      <= CNT_W'(1);
          end else begin
            spi_miso <= rd_sr[6];
            rd_sr    <= {rd_sr[5:0], 1'b0};
            cnt      <= cnt + CNT_W'(1);
          end
        end
        WRITE: begin
          spi_miso <= 1'b0;
          wr_sr    <= {wr_sr[5:0], spi_mosi};
          if (cnt == CNT_BYTE_END) begin
            addr <= addr_inc_c;
            cnt  <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        IGNORE: begin
          spi_miso <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          spi_miso <= 1'b0;
          busy     <= 1'b0;
          cnt      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nanov_spi_ram_responder.sv
// Bench for nanov_spi_ram_responder: transaction-level memory model drives expected
// miso/busy per edge; a negedge process compares, literals pin the model.
module tb_nanov_spi_ram_responder;

  localparam int unsigned AB    = 6;
  localparam int unsigned DEPTH = 2 ** AB;

  logic          clk;
  logic          rst;
  logic          spi_cs_n;
  logic          spi_mosi;
  logic          spi_miso;
  logic          busy;
  logic          host_wr_en;
  logic [AB-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic [7:0]    host_rdata;

  nanov_spi_ram_responder #(.ADDR_BITS(AB)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .busy       (busy),
    .host_wr_en (host_wr_en),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata)
  );

  logic [7:0] model_mem [DEPTH];
  logic [7:0] rd_bytes [8];
  logic [7:0] wr_bytes [4];
  logic       exp_miso;
  logic       exp_busy;
  logic       chk_en;
  int         passed;
  int         total;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Expected outputs describe the state after the most recent edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("spi_miso", {7'b0, spi_miso}, {7'b0, exp_miso});
      check("busy", {7'b0, busy}, {7'b0, exp_busy});
    end
  end

  task automatic step(input logic cs, input logic mosi, input logic em, input logic eb);
    spi_cs_n = cs;
    spi_mosi = mosi;
    @(posedge clk);
    #1;
    exp_miso   = em;
    exp_busy   = eb;
    host_wr_en = 1'b0;
  endtask

  task automatic host_write(input int a, input logic [7:0] d);
    host_wr_en = 1'b1;
    host_addr  = AB'(a);
    host_wdata = d;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    model_mem[a] = d;
  endtask

  task automatic end_cs();
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a24,
                          input logic last_em, input logic last_eb);
    logic [31:0] hdr;
    hdr = {cmd, a24};
    for (int i = 31; i >= 0; i--) begin
      if (i == 0) step(1'b0, hdr[i], last_em, last_eb);
      else        step(1'b0, hdr[i], 1'b0, 1'b0);
    end
  endtask

  // Expected read stream: bytes mem[a], mem[a+1], ... MSB first, wrapping modulo DEPTH.
  task automatic spi_read(input logic [23:0] a24, input int nbytes);
    int         a;
    logic [7:0] b;
    a = int'(a24[AB-1:0]);
    for (int k = 0; k < nbytes * 8; k++) begin
      b = model_mem[(a + k / 8) % DEPTH];
      if (k == 0) send_hdr(8'h03, a24, b[7], 1'b1);
      else        step(1'b0, 1'($urandom_range(0, 1)), b[7 - k % 8], 1'b1);
      rd_bytes[k / 8][7 - k % 8] = spi_miso;
    end
  endtask

  // Shifts nbits of wr_bytes; optional host write to the same byte on its commit edge.
  task automatic spi_write(input logic [23:0] a24, input int nbits,
                           input int coll_byte, input logic [7:0] coll_data);
    int         a;
    int         j;
    int         tgt;
    logic [7:0] b;
    logic       last;
    a = int'(a24[AB-1:0]);
    send_hdr(8'h02, a24, 1'b0, 1'b1);
    for (int k = 0; k < nbits; k++) begin
      j    = k / 8;
      b    = wr_bytes[j];
      tgt  = (a + j) % DEPTH;
      last = (k % 8 == 7);
      if (last && j == coll_byte) begin
        host_wr_en = 1'b1;
        host_addr  = AB'(tgt);
        host_wdata = coll_data;
      end
      step(1'b0, b[7 - k % 8], 1'b0, 1'b1);
      if (last) begin
        if (j == coll_byte) model_mem[tgt] = coll_data;
        model_mem[tgt] = b;
      end
    end
  endtask

  task automatic check_mem();
    for (int i = 0; i < int'(DEPTH); i++) begin
      host_addr = AB'(i);
      #1;
      check("host_rdata", host_rdata, model_mem[i]);
    end
  endtask

  task automatic peek(input string name, input int a, input logic [7:0] exp);
    host_addr = AB'(a);
    #1;
    check(name, host_rdata, exp);
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    chk_en     = 1'b0;
    exp_miso   = 1'b0;
    exp_busy   = 1'b0;
    rst        = 1'b1;
    spi_cs_n   = 1'b1;
    spi_mosi   = 1'b0;
    host_wr_en = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_miso", {7'b0, spi_miso}, 8'h00);
    check("reset_busy", {7'b0, busy}, 8'h00);
    rst    = 1'b0;
    chk_en = 1'b1;

    for (int i = 0; i < int'(DEPTH); i++) host_write(i, 8'(i * 37 + 11));
    host_write(5, 8'hA5);
    host_write(6, 8'h3C);
    host_write(10, 8'h5A);
    check_mem();

    // Preloaded read, streaming across three bytes
    spi_read(24'h000005, 3);
    check("read_byte0", rd_bytes[0], 8'hA5);
    check("read_byte1", rd_bytes[1], 8'h3C);
    end_cs();

    // Upper address bits are discarded
    spi_read(24'hABCD05, 1);
    check("read_hi_addr", rd_bytes[0], 8'hA5);
    end_cs();

    // Write burst wrapping 63 -> 0
    wr_bytes[0] = 8'h11;
    wr_bytes[1] = 8'h22;
    spi_write(24'h00003F, 16, -1, 8'h00);
    end_cs();
    peek("wrap_mem63", 63, 8'h11);
    peek("wrap_mem0", 0, 8'h22);
    check_mem();
    spi_read(24'h00003F, 2);
    check("wrap_read0", rd_bytes[0], 8'h11);
    check("wrap_read1", rd_bytes[1], 8'h22);
    end_cs();

    // Abort mid-byte discards the partial write
    wr_bytes[0] = 8'hFF;
    spi_write(24'h00000A, 5, -1, 8'h00);
    end_cs();
    peek("abort_mem10", 10, 8'h5A);
    spi_read(24'h00000A, 1);
    check("abort_read", rd_bytes[0], 8'h5A);
    end_cs();

    // Unknown command followed by junk
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] c;
      c = 8'h9F;
      step(1'b0, c[i], 1'b0, 1'b0);
    end
    repeat (40) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end_cs();
    check_mem();

    // Same-edge host/SPI write to one byte
    wr_bytes[0] = 8'h77;
    spi_write(24'h000004, 8, 0, 8'h88);
    end_cs();
    peek("collision_mem4", 4, 8'h77);

    // Reset mid-READ, then RAM still holds data
    spi_read(24'h000005, 1);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check("rst_mid_miso", {7'b0, spi_miso}, 8'h00);
    check("rst_mid_busy", {7'b0, busy}, 8'h00);
    end_cs();
    spi_read(24'h000006, 1);
    check("post_rst_read", rd_bytes[0], 8'h3C);
    end_cs();
    check_mem();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
